// File: rtl/pair_match_pkg.sv
// Shared constants and types for the pairwise match scorer.
// The match vector holds five lanes, and each lane is a row of five column bits.
package pair_match_pkg;

    localparam int NUM_LANES = 5;
    localparam int MATCH_W   = 25;

    localparam logic [MATCH_W-1:0] ALL_MATCH = 25'h1FFFFFF;
    // Diagonal bits 24, 18, 12, 6, 0: every lane must match itself.
    localparam logic [MATCH_W-1:0] DIAG_MASK = 25'h1041041;

    typedef logic [2:0] lane_idx_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int bit_idx(input int i, input int j);
        return MATCH_W - 1 - NUM_LANES * i - j;
    endfunction

endpackage

// File: rtl/match_row_decode.sv
// Decodes one match vector into per-lane agreement counts.
// It also flags a broken diagonal or an asymmetric vector.
module match_row_decode
    import pair_match_pkg::*;
(
    input  logic [MATCH_W-1:0]              match_i,
    output logic [NUM_LANES-1:0][2:0]       agree_o,
    output logic                            malformed_o
);

    always_comb begin
        agree_o     = '0;
        malformed_o = ((match_i & DIAG_MASK) != DIAG_MASK);
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < NUM_LANES; j++) begin
                agree_o[i] = agree_o[i] + {2'b00, match_i[bit_idx(i, j)]};
                if (match_i[bit_idx(i, j)] != match_i[bit_idx(j, i)]) begin
                    malformed_o = 1'b1;
                end
            end
            // The self-match bit does not count as agreement.
            agree_o[i] = agree_o[i] - 3'd1;
        end
    end

endmodule

// File: rtl/pair_match_scorer.sv
// Accumulates per-lane agreement scores over a window of match vectors.
// The result is presented on a valid/ready output and held until it is consumed.
module pair_match_scorer
    import pair_match_pkg::*;
#(
    parameter  int WINDOW  = 8,
    localparam int SCORE_W = $clog2(4 * WINDOW + 1),
    localparam int CNT_W   = $clog2(WINDOW + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [MATCH_W-1:0]           in_match,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_LANES*SCORE_W-1:0] out_score,
    output logic [2:0]                   out_winner,
    output logic                         out_unanimous,
    output logic                         out_malformed,
    output logic [CNT_W-1:0]             out_count
);

    state_t                              state_q, state_d;
    logic [NUM_LANES-1:0][SCORE_W-1:0]   score_q, score_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic                                unan_q, unan_d;
    logic                                malf_q, malf_d;

    logic [NUM_LANES-1:0][2:0]           agree;
    logic                                row_malf;
    logic                                accept;
    lane_idx_t                           win;
    logic [SCORE_W-1:0]                  best;

    match_row_decode u_decode (
        .match_i     (in_match),
        .agree_o     (agree),
        .malformed_o (row_malf)
    );

    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == HOLD);
    assign accept        = in_valid & in_ready;
    assign out_count     = cnt_q;
    assign out_unanimous = unan_q;
    assign out_malformed = malf_q;
    assign out_winner    = win;

    always_comb begin
        out_score = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            out_score[SCORE_W*(NUM_LANES-i)-1 -: SCORE_W] = score_q[i];
        end
    end

    // Strict compare keeps the lowest lane index on a tie.
    always_comb begin
        win  = '0;
        best = score_q[0];
        for (int i = 1; i < NUM_LANES; i++) begin
            if (score_q[i] > best) begin
                best = score_q[i];
                win  = lane_idx_t'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        unan_d  = unan_q;
        malf_d  = malf_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (row_malf) begin
                        malf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            score_d[i] = score_q[i] + SCORE_W'(agree[i]);
                        end
                        unan_d = unan_q & (in_match == ALL_MATCH);
                    end
                end
                if ((accept && cnt_d == CNT_W'(WINDOW)) ||
                    (flush && cnt_d != '0)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    score_d = '0;
                    cnt_d   = '0;
                    unan_d  = 1'b1;
                    malf_d  = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            score_q <= '0;
            cnt_q   <= '0;
            unan_q  <= 1'b1;
            malf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            cnt_q   <= cnt_d;
            unan_q  <= unan_d;
            malf_q  <= malf_d;
        end
    end

endmodule

// File: tb/tb_pair_match_scorer.sv
// Scoreboard bench for pair_match_scorer with WINDOW=4.
// Expected results are queued at issue, and a monitor checks each handshake.
module tb_pair_match_scorer;

    localparam int W  = 4;
    localparam int SW = 5;
    localparam int CW = 3;

    typedef struct packed {
        logic [5*SW-1:0] score;
        logic [2:0]      win;
        logic            unan;
        logic            malf;
        logic [CW-1:0]   cnt;
    } exp_t;

    logic            clk = 0;
    logic            reset = 1;
    logic            in_valid = 0;
    logic            in_ready;
    logic [24:0]     in_match = '0;
    logic            flush = 0;
    logic            out_valid;
    logic            out_ready = 1;
    logic [5*SW-1:0] out_score;
    logic [2:0]      out_winner;
    logic            out_unanimous;
    logic            out_malformed;
    logic [CW-1:0]   out_count;

    int   tests = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t e;

    pair_match_scorer #(.WINDOW(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_match      (in_match),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_score     (out_score),
        .out_winner    (out_winner),
        .out_unanimous (out_unanimous),
        .out_malformed (out_malformed),
        .out_count     (out_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name,
                                input logic [31:0] got,
                                input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic exp_t mk(input int s0, input int s1, input int s2,
                                input int s3, input int s4, input int w,
                                input bit u, input bit m, input int c);
        exp_t r;
        r.score = {SW'(s0), SW'(s1), SW'(s2), SW'(s3), SW'(s4)};
        r.win   = 3'(w);
        r.unan  = u;
        r.malf  = m;
        r.cnt   = CW'(c);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got score %h expected none",
                         out_score);
            end else begin
                e = q.pop_front();
                chk("res_score", 32'(out_score), 32'(e.score));
                chk("res_winner", 32'(out_winner), 32'(e.win));
                chk("res_unanimous", 32'(out_unanimous), 32'(e.unan));
                chk("res_malformed", 32'(out_malformed), 32'(e.malf));
                chk("res_count", 32'(out_count), 32'(e.cnt));
            end
        end
    end

    task automatic send(input logic [24:0] m);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        in_valid = 1;
        in_match = m;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_count"}, 32'(out_count), 32'd0);
        chk({tag, "_score"}, 32'(out_score), 32'd0);
        chk({tag, "_unanimous"}, 32'(out_unanimous), 32'd1);
        chk({tag, "_malformed"}, 32'(out_malformed), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk_idle("reset");
        chk("reset_winner", 32'(out_winner), 32'd0);

        // all lanes in full agreement
        q.push_back(mk(16, 16, 16, 16, 16, 0, 1, 0, 4));
        repeat (4) send(25'h1FFFFFF);
        chk("t1_valid_latency", 32'(out_valid), 32'd1);
        drain();

        // lane a disagrees with everyone
        q.push_back(mk(0, 12, 12, 12, 12, 1, 0, 0, 4));
        repeat (4) send(25'h107BDEF);
        drain();

        // one malformed sample, then three all-ones
        q.push_back(mk(12, 12, 12, 12, 12, 0, 1, 1, 4));
        send(25'h0000000);
        repeat (3) send(25'h1FFFFFF);
        drain();

        // stalled output: only d and e agree, tie -> lane 3
        out_ready = 0;
        q.push_back(mk(0, 0, 0, 4, 4, 3, 0, 0, 4));
        repeat (4) send(25'h1041063);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_score", 32'(out_score), 32'h0000084);
            chk("stall_winner", 32'(out_winner), 32'd3);
            chk("stall_count", 32'(out_count), 32'd4);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        chk_idle("after_stall");
        chk("stall_consumed", 32'(q.size()), 32'd0);

        // early flush, then a flush on an empty window
        q.push_back(mk(8, 8, 8, 8, 8, 0, 1, 0, 2));
        repeat (2) send(25'h1FFFFFF);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        drain();
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        repeat (3) @(posedge clk);
        #1 chk("empty_flush_no_output", 32'(out_valid), 32'd0);

        // reset discards a partial window
        repeat (3) send(25'h1FFFFFF);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk_idle("midreset");
        q.push_back(mk(0, 12, 12, 12, 12, 1, 0, 0, 4));
        repeat (4) send(25'h107BDEF);
        drain();

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
